treemux_rr_arbiter: RTL

- Round-robin ingress arbiter that sits directly upstream of a treemux tree.
- Accepts up to N independent valid/ready producer streams and buffers one beat per port.
- Each cycle it grants at most one port, so the downstream mux tree sees at most one valid lane per cycle, as its select logic requires.
- Honours a single downstream `out_ready` throttle and guarantees starvation-free service.

---
 rtl/treemux_pkg.sv | 14 +
 rtl/treemux_rr_arbiter_if.sv | 22 ++
 rtl/treemux_rr_pick.sv | 21 ++
 rtl/treemux_rr_arbiter.sv | 67 ++++++
 4 files changed

// File: rtl/treemux_pkg.sv
// treemux_pkg: shared constants and pointer helpers for the treemux arbiter family.
package treemux_pkg;

    localparam int TREEMUX_MAX_N = 16;

    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int rr_next(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/treemux_rr_arbiter_if.sv
// treemux_rr_arbiter_if: producer-side valid/ready ports and tree-side lane outputs.
interface treemux_rr_arbiter_if #(
    parameter int WIDTH = 72,
    parameter int N     = 4
);
    logic [WIDTH-1:0] in_data [N-1:0];
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             out_ready;
    logic [WIDTH-1:0] out_data [N-1:0];
    logic [N-1:0]     out_valid;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/treemux_rr_pick.sv
// treemux_rr_pick: one-hot round-robin select starting at ptr, via a double-width masked priority encode.
module treemux_rr_pick
    import treemux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [ptr_w(N)-1:0]    ptr,
    input  logic                   en,
    output logic [N-1:0]           gnt
);
    logic [N-1:0]   low;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] iso;

    // Lower copy drops requests below ptr; upper copy supplies the wrap-around.
    assign low = (N'(1) << ptr) - N'(1);
    assign dbl = {req, req & ~low};
    assign iso = dbl & (~dbl + (2*N)'(1));
    assign gnt = en ? (iso[N-1:0] | iso[2*N-1:N]) : '0;
endmodule

// File: rtl/treemux_rr_arbiter.sv
// treemux_rr_arbiter: per-port one-beat buffers feeding a round-robin, one-lane-per-cycle
// registered output towards a treemux tree.
module treemux_rr_arbiter
    import treemux_pkg::*;
#(
    parameter int WIDTH = 72,
    parameter int N     = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    treemux_rr_arbiter_if.slave  bus
);
    localparam int PW = ptr_w(N);

    logic [N-1:0]     hold_valid;
    logic [WIDTH-1:0] hold_data [N-1:0];
    logic [N-1:0]     grant;
    logic [N-1:0]     ready;
    logic [N-1:0]     accept;
    logic [N-1:0]     out_valid;
    logic [WIDTH-1:0] out_data [N-1:0];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_next;

    treemux_rr_pick #(.N(N)) u_pick (
        .req (hold_valid),
        .ptr (ptr),
        .en  (bus.out_ready),
        .gnt (grant)
    );

    // A granted port drains this edge, so it may refill in the same cycle.
    assign ready        = ~{N{RST}} & (~hold_valid | grant);
    assign accept       = bus.in_valid & ready;
    assign bus.in_ready = ready;
    assign bus.out_valid = out_valid;

    for (genvar l = 0; l < N; l++) begin : g_lane
        assign bus.out_data[l] = out_data[l];
    end

    always_comb begin
        ptr_next = ptr;
        for (int i = 0; i < N; i++)
            if (grant[i]) ptr_next = PW'(rr_next(i, N));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_valid <= '0;
            out_valid  <= '0;
            ptr        <= '0;
            for (int i = 0; i < N; i++) begin
                hold_data[i] <= '0;
                out_data[i]  <= '0;
            end
        end else begin
            hold_valid <= accept | (hold_valid & ~grant);
            out_valid  <= grant;
            ptr        <= ptr_next;
            for (int i = 0; i < N; i++) begin
                if (accept[i]) hold_data[i] <= bus.in_data[i];
                if (grant[i]) out_data[i] <= hold_data[i];
            end
        end
    end
endmodule
